// File: rtl/delay_unit.sv
`default_nettype none
// ============================================================================
//  Module      : delay_unit
//  Description : Fixed-latency handshake delay stage. A word accepted on
//                valid/next is presented on out with a one-cycle ready
//                strobe exactly delay_time cycles after acceptance.
//                delay_time = 0 degenerates to a single-register stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module delay_unit #(
    parameter int delay_time = 0,   // cycles from acceptance to output
    parameter int cnt_size   = 4,   // counter width, delay_time <= 2**cnt_size-1
    parameter int delay_size = 8    // data word width
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid,
    input  logic [delay_size-1:0] in,
    output logic [delay_size-1:0] out,
    output logic                  ready,
    output logic                  next
);

    generate
        if (delay_time == 0) begin : g_pass
            // Pass-through: always accepting, one word per cycle.
            logic [delay_size-1:0] out_d;
            logic [delay_size-1:0] out_q;
            logic                  ready_d;
            logic                  ready_q;

            // Capture the word on every valid edge; hold out otherwise.
            always_comb begin
                out_d   = out_q;
                ready_d = 1'b0;
                if (valid) begin
                    out_d   = in;
                    ready_d = 1'b1;
                end
            end

            // Output registers with asynchronous clear.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_q   <= '0;
                    ready_q <= 1'b0;
                end else begin
                    out_q   <= out_d;
                    ready_q <= ready_d;
                end
            end

            assign out   = out_q;
            assign ready = ready_q;
            assign next  = 1'b1;
        end else begin : g_fsm
            typedef enum logic {
                S_IDLE  = 1'b0,
                S_COUNT = 1'b1
            } state_t;

            // Counter value at which the held word is released.
            localparam logic [cnt_size-1:0] C_LAST = cnt_size'(delay_time);

            state_t                state_d;
            state_t                state_q;
            logic [cnt_size-1:0]   cnt_d;
            logic [cnt_size-1:0]   cnt_q;
            logic [delay_size-1:0] data_d;
            logic [delay_size-1:0] data_q;
            logic [delay_size-1:0] out_d;
            logic [delay_size-1:0] out_q;
            logic                  ready_d;
            logic                  ready_q;
            logic                  next_d;
            logic                  next_q;

            // Next-state logic: accept in IDLE, count, release at C_LAST.
            // next_q is high exactly in IDLE, so valid alone means acceptance there.
            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                data_d  = data_q;
                out_d   = out_q;
                ready_d = 1'b0;
                next_d  = next_q;
                case (state_q)
                    S_IDLE: begin
                        if (valid) begin
                            data_d  = in;
                            cnt_d   = cnt_size'(1);
                            next_d  = 1'b0;
                            state_d = S_COUNT;
                        end
                    end
                    S_COUNT: begin
                        if (cnt_q == C_LAST) begin
                            out_d   = data_q;
                            ready_d = 1'b1;
                            next_d  = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_d = S_IDLE;
                        next_d  = 1'b1;
                    end
                endcase
            end

            // State and output registers; reset aborts any word in flight.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                    data_q  <= '0;
                    out_q   <= '0;
                    ready_q <= 1'b0;
                    next_q  <= 1'b1;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                    data_q  <= data_d;
                    out_q   <= out_d;
                    ready_q <= ready_d;
                    next_q  <= next_d;
                end
            end

            assign out   = out_q;
            assign ready = ready_q;
            assign next  = next_q;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_delay_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_delay_unit
//  Description : Bench for delay_unit with four instances (delay 0, 3, 5, 15)
//                sharing clock and reset, compared against a timing model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_delay_unit;

    localparam int DT [4] = '{0, 3, 5, 15};

    logic       clk     = 1'b0;
    logic       clk_run = 1'b0;
    logic       rst_n   = 1'b1;
    logic       v [4];
    logic [7:0] d [4];
    logic [7:0] o [4];
    logic       r [4];
    logic       n [4];

    int checks   = 0;
    int failures = 0;

    // Reference model: acceptance/delivery expressed as edge indices.
    int         edge_cnt = 0;
    int         avail     [4];   // first edge at which a word may be accepted
    int         pend_edge [4];   // edge at which the pending word appears
    logic [7:0] pend_word [4];
    bit         has       [4];
    logic [7:0] e_out     [4];
    logic       e_rdy     [4];
    logic       e_nxt     [4];

    always #5 if (clk_run) clk = ~clk;

    delay_unit #(.delay_time(0), .cnt_size(4), .delay_size(8)) u_dt0 (
        .clk(clk), .rst_n(rst_n), .valid(v[0]), .in(d[0]),
        .out(o[0]), .ready(r[0]), .next(n[0]));
    delay_unit #(.delay_time(3), .cnt_size(4), .delay_size(8)) u_dt3 (
        .clk(clk), .rst_n(rst_n), .valid(v[1]), .in(d[1]),
        .out(o[1]), .ready(r[1]), .next(n[1]));
    delay_unit #(.delay_time(5), .cnt_size(4), .delay_size(8)) u_dt5 (
        .clk(clk), .rst_n(rst_n), .valid(v[2]), .in(d[2]),
        .out(o[2]), .ready(r[2]), .next(n[2]));
    delay_unit #(.delay_time(15), .cnt_size(4), .delay_size(8)) u_dt15 (
        .clk(clk), .rst_n(rst_n), .valid(v[3]), .in(d[3]),
        .out(o[3]), .ready(r[3]), .next(n[3]));

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            avail[k] = 0;
            has[k]   = 1'b0;
            e_out[k] = 8'h00;
            e_rdy[k] = 1'b0;
            e_nxt[k] = 1'b1;
        end
    endtask

    task automatic check_all(input string phase);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s.dt%0d.out", phase, DT[k]), o[k], e_out[k]);
            chk($sformatf("%s.dt%0d.ready", phase, DT[k]), {7'b0, r[k]}, {7'b0, e_rdy[k]});
            chk($sformatf("%s.dt%0d.next", phase, DT[k]), {7'b0, n[k]}, {7'b0, e_nxt[k]});
        end
    endtask

    // One rising edge: advance the model, then sample outputs 1 time unit later.
    task automatic tick(input string phase);
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            e_rdy[k] = 1'b0;
            if (v[k] && edge_cnt >= avail[k]) begin
                has[k]       = 1'b1;
                pend_edge[k] = edge_cnt + DT[k];
                pend_word[k] = d[k];
                avail[k]     = edge_cnt + DT[k] + 1;
            end
            if (has[k] && pend_edge[k] == edge_cnt) begin
                e_out[k] = pend_word[k];
                e_rdy[k] = 1'b1;
                has[k]   = 1'b0;
            end
            e_nxt[k] = (edge_cnt + 1 >= avail[k]);
        end
        edge_cnt++;
        #1;
        check_all(phase);
    endtask

    task automatic idle_all();
        for (int k = 0; k < 4; k++) begin
            v[k] = 1'b0;
            d[k] = 8'h00;
        end
    endtask

    task automatic randomize_inputs(input bit force_valid_max);
        for (int k = 0; k < 4; k++) begin
            v[k] = ($urandom_range(0, 3) != 0);
            d[k] = 8'($urandom);
        end
        if (force_valid_max) v[3] = 1'b1;
    endtask

    initial begin
        idle_all();
        model_reset();

        // Reset with clock stopped: outputs must clear immediately.
        #1 rst_n = 1'b0;
        #2 check_all("reset");
        #2 rst_n = 1'b1;
        #1 check_all("reset_release");
        clk_run = 1'b1;
        tick("idle");
        tick("idle");

        // Directed: stream A5,3C,FF into delay 0; 5A then ignored 11 into delay 3.
        v[0] = 1'b1; d[0] = 8'hA5;
        v[1] = 1'b1; d[1] = 8'h5A;
        tick("dir");
        d[0] = 8'h3C;
        v[1] = 1'b0; d[1] = 8'h00;
        tick("dir");
        d[0] = 8'hFF;
        v[1] = 1'b1; d[1] = 8'h11;
        tick("dir");
        idle_all();
        for (int i = 0; i < 6; i++) tick("dir");

        // Randomized traffic on all instances.
        for (int i = 0; i < 300; i++) begin
            randomize_inputs(1'b0);
            tick("rand");
        end

        // Reset mid-count on the delay-5 instance.
        idle_all();
        for (int i = 0; i < 20; i++) tick("drain");
        v[2] = 1'b1; d[2] = 8'h77;
        tick("rstmid");
        idle_all();
        tick("rstmid");
        tick("rstmid");
        rst_n = 1'b0;
        model_reset();
        #1 check_all("rstmid_async");
        #1 rst_n = 1'b1;
        v[2] = 1'b1; d[2] = 8'h22;
        tick("after_rst");
        idle_all();
        for (int i = 0; i < 8; i++) tick("after_rst");

        // Maximum delay: valid held high on the delay-15 instance.
        for (int i = 0; i < 64; i++) begin
            randomize_inputs(1'b1);
            tick("maxdly");
        end
        idle_all();
        for (int i = 0; i < 20; i++) tick("tail");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
